// File: rtl/ahb_params_pkg.sv
// rtl/ahb_params_pkg.sv - shared AHB encodings and arbiter constants
package ahb_params_pkg;

  localparam int NO_OF_MASTERS = 4;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11} hresp_e;

  typedef enum logic [1:0] {FREE = 2'b00, BURST = 2'b01, LOCKED = 2'b10} arb_state_e;

  // Beat counter load after the NONSEQ beat: the counter hits zero on the
  // second-to-last beat so the last SEQ beat can re-arbitrate.
  function automatic logic [3:0] burst_cnt_init(input hburst_e b);
    case (b)
      WRAP4, INCR4:   return 4'd2;
      WRAP8, INCR8:   return 4'd6;
      WRAP16, INCR16: return 4'd14;
      default:        return 4'd0;
    endcase
  endfunction

  function automatic logic burst_holds(input hburst_e b);
    return (b != SINGLE) && (b != INCR);
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - combinational round-robin winner select after rr_ptr
module ahb_rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] rr_ptr,
  output logic [N-1:0] winner,
  output logic [W-1:0] winner_idx,
  output logic         valid
);

  logic [W-1:0] cand;

  // Scan from farthest to nearest so the nearest eligible master after rr_ptr wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int k = N; k >= 1; k--) begin
      cand = W'((int'(rr_ptr) + k) % N);
      if (eligible[cand]) begin
        winner       = '0;
        winner[cand] = 1'b1;
        winner_idx   = cand;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - AHB arbiter: round-robin grant, burst hold, locked sequences, split masking
module ahb_bus_arbiter #(
  parameter int NO_OF_MASTERS  = ahb_params_pkg::NO_OF_MASTERS,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NO_OF_MASTERS)
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
  input  logic [NO_OF_MASTERS-1:0] HLOCK,
  input  logic [NO_OF_MASTERS-1:0] HSPLIT,
  input  logic [1:0]               HTRANS,
  input  logic [2:0]               HBURST,
  input  logic                     HREADY,
  input  logic [1:0]               HRESP,
  output logic [NO_OF_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]            HMASTER,
  output logic                     HMASTLOCK
);
  import ahb_params_pkg::*;

  typedef logic [NO_OF_MASTERS-1:0] vec_t;
  localparam logic [MW-1:0] DEF_IDX   = MW'(DEFAULT_MASTER);
  localparam vec_t          DEF_GRANT = vec_t'(1) << DEFAULT_MASTER;

  arb_state_e    state, state_nxt;
  vec_t          split_mask, mask_nxt, grant_nxt, pick;
  logic [MW-1:0] owner, rr_ptr, rr_nxt, data_master, pick_idx;
  logic [3:0]    beat_cnt, beat_nxt;
  logic          pick_valid, rearb, split_rsp;
  htrans_e       trans;
  hburst_e       burst;

  assign trans     = htrans_e'(HTRANS);
  assign burst     = hburst_e'(HBURST);
  assign split_rsp = HREADY && (hresp_e'(HRESP) == SPLIT);

  always_comb begin
    owner = '0;
    for (int i = 0; i < NO_OF_MASTERS; i++)
      if (HGRANT[i]) owner = MW'(i);
  end

  // Resume strobes clear after the split set so a same-cycle collision un-masks.
  always_comb begin
    mask_nxt = split_mask;
    if (split_rsp && data_master != DEF_IDX) mask_nxt[data_master] = 1'b1;
    mask_nxt = mask_nxt & ~HSPLIT;
  end

  ahb_rr_picker #(.N(NO_OF_MASTERS), .W(MW)) u_picker (
    .eligible   (HBUSREQ & ~mask_nxt),
    .rr_ptr     (rr_ptr),
    .winner     (pick),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    rearb     = 1'b0;
    if (split_rsp) begin
      state_nxt = FREE;
      rearb     = 1'b1;
    end else begin
      case (state)
        FREE: begin
          if (HLOCK[owner]) begin
            state_nxt = LOCKED;
          end else if (trans == NONSEQ && burst_holds(burst)) begin
            state_nxt = BURST;
            beat_nxt  = burst_cnt_init(burst);
          end else begin
            rearb = 1'b1;
          end
        end
        BURST: begin
          if (trans == SEQ) begin
            if (beat_cnt == 4'd0) begin
              state_nxt = FREE;
              rearb     = 1'b1;
            end else begin
              beat_nxt = beat_cnt - 4'd1;
            end
          end else if (trans != BUSY) begin
            state_nxt = FREE;
            rearb     = 1'b1;
          end
        end
        LOCKED: begin
          if (!HLOCK[owner]) begin
            state_nxt = FREE;
            rearb     = 1'b1;
          end
        end
        default: begin
          state_nxt = FREE;
          rearb     = 1'b1;
        end
      endcase
    end

    grant_nxt = HGRANT;
    rr_nxt    = rr_ptr;
    if (rearb) begin
      if (pick_valid) begin
        grant_nxt = pick;
        rr_nxt    = pick_idx;
      end else begin
        grant_nxt = DEF_GRANT;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= FREE;
      HGRANT      <= DEF_GRANT;
      HMASTER     <= DEF_IDX;
      HMASTLOCK   <= 1'b0;
      data_master <= DEF_IDX;
      rr_ptr      <= DEF_IDX;
      beat_cnt    <= 4'd0;
      split_mask  <= '0;
    end else begin
      split_mask <= mask_nxt;
      if (HREADY) begin
        state       <= state_nxt;
        HGRANT      <= grant_nxt;
        HMASTER     <= owner;
        HMASTLOCK   <= HLOCK[owner] && (|HGRANT);
        data_master <= HMASTER;
        rr_ptr      <= rr_nxt;
        beat_cnt    <= beat_nxt;
      end
    end
  end

  hgrant_onehot: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(HGRANT));

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb/tb_ahb_bus_arbiter.sv - directed bench with cycle model for ahb_bus_arbiter
module tb_ahb_bus_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic [3:0] HBUSREQ = '0, HLOCK = '0, HSPLIT = '0;
  logic [1:0] HTRANS = 2'b00, HRESP = 2'b00;
  logic [2:0] HBURST = 3'b000;
  logic       HREADY = 1'b1;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  ahb_bus_arbiter #(.NO_OF_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HSPLIT(HSPLIT),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: grant kept as an index, hold reason 0=none 1=burst 2=lock,
  // m_left = SEQ beats still owed by the current burst.
  int m_gnt, m_mst, m_dm, m_rr, m_hold, m_left, m_lock;
  bit [3:0] m_mask;

  always @(posedge HCLK) begin
    bit [3:0] nm;
    int own, w, c;
    bit rearb, found;
    if (HRESET) begin
      m_gnt = 0; m_mst = 0; m_dm = 0; m_rr = 0;
      m_hold = 0; m_left = 0; m_lock = 0; m_mask = '0;
    end else begin
      nm = m_mask;
      if (HREADY && HRESP == 2'b11 && m_dm != 0) nm[m_dm[1:0]] = 1'b1;
      nm = nm & ~HSPLIT;
      if (HREADY) begin
        own   = m_gnt;
        rearb = 1'b1;
        if (HRESP == 2'b11) m_hold = 0;
        else if (m_hold == 2) begin
          if (HLOCK[own[1:0]]) rearb = 1'b0; else m_hold = 0;
        end else if (m_hold == 1) begin
          if (HTRANS == 2'b01) rearb = 1'b0;
          else if (HTRANS == 2'b11) begin
            m_left--;
            if (m_left > 0) rearb = 1'b0; else m_hold = 0;
          end else m_hold = 0;
        end else if (HLOCK[own[1:0]]) begin
          m_hold = 2; rearb = 1'b0;
        end else if (HTRANS == 2'b10 && HBURST >= 3'd2) begin
          m_hold = 1; m_left = (4 << ((int'(HBURST) - 2) / 2)) - 1; rearb = 1'b0;
        end
        m_dm   = m_mst;
        m_mst  = own;
        m_lock = int'(HLOCK[own[1:0]]);
        if (rearb) begin
          found = 1'b0; w = 0;
          for (int k = 1; k <= 4; k++) begin
            c = (m_rr + k) % 4;
            if (!found && HBUSREQ[c[1:0]] && !nm[c[1:0]]) begin w = c; found = 1'b1; end
          end
          if (found) m_rr = w;
          m_gnt = found ? w : 0;
        end
      end
      m_mask = nm;
    end
  end

  always @(negedge HCLK) begin
    if (cmp_en) begin
      check("model_hgrant", int'(HGRANT), 1 << m_gnt);
      check("model_hmaster", int'(HMASTER), m_mst);
      check("model_hmastlock", int'(HMASTLOCK), m_lock);
      check("hgrant_onehot", $countones(HGRANT), 1);
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  int exp_g[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
  int exp_m[4] = '{0, 1, 2, 3};

  initial begin
    step(); step();
    check("reset_hgrant", int'(HGRANT), 4'b0001);
    check("reset_hmaster", int'(HMASTER), 0);
    check("reset_hmastlock", int'(HMASTLOCK), 0);
    cmp_en = 1'b1;

    HRESET = 1'b0; HBUSREQ = 4'b1110; HTRANS = 2'b10; HBURST = 3'b000;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_hgrant", int'(HGRANT), exp_g[i]);
      check("rr_hmaster", int'(HMASTER), exp_m[i]);
    end

    HBUSREQ = 4'b0100; HTRANS = 2'b00;
    step();
    check("burst_pre_grant", int'(HGRANT), 4'b0100);
    HBUSREQ = 4'b0110; HTRANS = 2'b10; HBURST = 3'b011;
    step(); check("burst_nonseq", int'(HGRANT), 4'b0100);
    HTRANS = 2'b11;
    step(); check("burst_seq1", int'(HGRANT), 4'b0100);
    HTRANS = 2'b01;
    step(); check("burst_busy", int'(HGRANT), 4'b0100);
    HTRANS = 2'b11; HREADY = 1'b0;
    step(); check("burst_stall", int'(HGRANT), 4'b0100);
    HREADY = 1'b1;
    step(); check("burst_seq2", int'(HGRANT), 4'b0100);
    step(); check("burst_release", int'(HGRANT), 4'b0010);

    HTRANS = 2'b10; HBURST = 3'b000; HBUSREQ = 4'b1110; HLOCK = 4'b1000;
    step(); step();
    check("lock_grant", int'(HGRANT), 4'b1000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("lock_hold", int'(HGRANT), 4'b1000);
      check("lock_hmastlock", int'(HMASTLOCK), 1);
    end
    HLOCK = 4'b0000;
    step();
    check("lock_release_grant", int'(HGRANT), 4'b0010);
    check("lock_release_mastlock", int'(HMASTLOCK), 0);

    HBUSREQ = 4'b0010;
    step(); step();
    HRESP = 2'b11;
    step(); check("split_mask_default", int'(HGRANT), 4'b0001);
    HRESP = 2'b00; HBUSREQ = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      step(); check("split_m1_excluded", int'(HGRANT), 4'b0100);
    end
    HSPLIT = 4'b0010;
    step(); check("split_resume", int'(HGRANT), 4'b0010);
    HSPLIT = 4'b0000; HBUSREQ = 4'b0010;
    step(); step();
    HRESP = 2'b11; HSPLIT = 4'b0010;
    step(); check("split_clear_wins", int'(HGRANT), 4'b0010);
    HRESP = 2'b00; HSPLIT = 4'b0000; HBUSREQ = 4'b0000;
    step(); check("no_request_default", int'(HGRANT), 4'b0001);

    HBUSREQ = 4'b0100; HLOCK = 4'b0100; HTRANS = 2'b00;
    step(); step();
    HTRANS = 2'b10; HBURST = 3'b101;
    step();
    check("mid_lock_grant", int'(HGRANT), 4'b0100);
    check("mid_lock_mastlock", int'(HMASTLOCK), 1);
    HRESET = 1'b1;
    step();
    check("mid_reset_hgrant", int'(HGRANT), 4'b0001);
    check("mid_reset_hmaster", int'(HMASTER), 0);
    check("mid_reset_hmastlock", int'(HMASTLOCK), 0);
    HRESET = 1'b0; HBUSREQ = 4'b1110; HLOCK = 4'b0000; HTRANS = 2'b00; HBURST = 3'b000;
    step(); check("post_reset_rr", int'(HGRANT), 4'b0010);
    step();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
